// File: rtl/sigmoid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sigmoid_pkg
// Description : Shared types and Q16 constants for the piecewise sigmoid/tanh pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package sigmoid_pkg;

    typedef enum logic {
        OP_SIG  = 1'b0,
        OP_TANH = 1'b1
    } op_e;

    localparam int unsigned c_tag_lanes = 4;
    localparam int unsigned c_tag_idxw  = 5;

    // Breakpoints and segment offsets, expressed with 16 fractional bits.
    localparam logic [31:0] c_q16_bp_one = 32'h0001_0000;   // 1.0
    localparam logic [31:0] c_q16_bp_mid = 32'h0002_6000;   // 2.375
    localparam logic [31:0] c_q16_bp_sat = 32'h0005_0000;   // 5.0
    localparam logic [31:0] c_q16_off_lo  = 32'h0000_8000;  // 0.5
    localparam logic [31:0] c_q16_off_mid = 32'h0000_A000;  // 0.625
    localparam logic [31:0] c_q16_off_hi  = 32'h0000_D800;  // 0.84375

    localparam logic [1:0] c_seg_lo  = 2'd0;
    localparam logic [1:0] c_seg_mid = 2'd1;
    localparam logic [1:0] c_seg_hi  = 2'd2;
    localparam logic [1:0] c_seg_sat = 2'd3;

    typedef struct packed {
        logic                   reg_wen;
        logic [c_tag_lanes-1:0] word_sel;
        logic [c_tag_idxw-1:0]  index;
        op_e                    op;
    } stage_tag_t;

    function automatic logic [63:0] q16_rescale(input logic [31:0] v, input int frac);
        if (frac >= 16) begin
            return {32'd0, v} << (frac - 16);
        end else begin
            return {32'd0, v} >> (16 - frac);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sigmoid_lane.sv
`default_nettype none
// ============================================================================
// Module      : sigmoid_lane
// Description : One lane of the 3-stage PLAN sigmoid / tanh evaluator.
// Revision    : 1.0 - initial release
// ============================================================================
module sigmoid_lane
    import sigmoid_pkg::*;
#(
    parameter int DW   = 32,
    parameter int FRAC = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [2:0]    ld,
    input  logic          flush,
    input  logic          op_s1,
    input  logic          op_s3,
    input  logic          en,
    input  logic [DW-1:0] x,
    output logic [DW-1:0] y,
    output logic          err
);

    localparam logic [DW-1:0] c_zero    = '0;
    localparam logic [DW-1:0] c_min     = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] c_max     = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] c_one     = DW'(q16_rescale(c_q16_bp_one, FRAC));
    localparam logic [DW-1:0] c_bp_mid  = DW'(q16_rescale(c_q16_bp_mid, FRAC));
    localparam logic [DW-1:0] c_bp_sat  = DW'(q16_rescale(c_q16_bp_sat, FRAC));
    localparam logic [DW-1:0] c_off_lo  = DW'(q16_rescale(c_q16_off_lo, FRAC));
    localparam logic [DW-1:0] c_off_mid = DW'(q16_rescale(c_q16_off_mid, FRAC));
    localparam logic [DW-1:0] c_off_hi  = DW'(q16_rescale(c_q16_off_hi, FRAC));

    logic [DW-1:0] w_x2;
    logic [DW-1:0] w_xin;
    logic [DW-1:0] w_abs;
    logic          w_neg;
    logic [1:0]    w_seg;

    logic [DW-3:0] r1_aq;
    logic [1:0]    r1_seg;
    logic          r1_neg;
    logic          r1_err;

    logic [DW-1:0] w_y;
    logic [DW-1:0] r2_y;
    logic          r2_neg;
    logic          r2_err;

    logic [DW-1:0] w_ys;
    logic [DW-1:0] w_tanh;
    logic [DW-1:0] w_res;

    // Stage 1: tanh pre-doubling with saturation, magnitude, segment pick.
    always_comb begin
        if (x[DW-1] != x[DW-2]) begin
            w_x2 = x[DW-1] ? c_min : c_max;
        end else begin
            w_x2 = {x[DW-2:0], 1'b0};
        end
        w_xin = (op_e'(op_s1) == OP_TANH) ? w_x2 : x;
        w_neg = w_xin[DW-1];
        w_abs = w_neg ? (c_zero - w_xin) : w_xin;
        if (w_abs >= c_bp_sat) begin
            w_seg = c_seg_sat;
        end else if (w_abs >= c_bp_mid) begin
            w_seg = c_seg_hi;
        end else if (w_abs >= c_one) begin
            w_seg = c_seg_mid;
        end else begin
            w_seg = c_seg_lo;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r1_aq  <= '0;
            r1_seg <= c_seg_lo;
            r1_neg <= 1'b0;
            r1_err <= 1'b0;
        end else if (ld[0]) begin
            r1_aq  <= w_abs[DW-1:2];
            r1_seg <= w_seg;
            r1_neg <= w_neg;
            r1_err <= (x == c_min);
        end
    end

    // Stage 2: r1_aq already holds a/4, so a/8 and a/32 are further shifts of it.
    always_comb begin
        case (r1_seg)
            c_seg_sat: w_y = c_one;
            c_seg_hi:  w_y = {5'b00000, r1_aq[DW-3:3]} + c_off_hi;
            c_seg_mid: w_y = {3'b000, r1_aq[DW-3:1]} + c_off_mid;
            default:   w_y = {2'b00, r1_aq} + c_off_lo;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r2_y   <= '0;
            r2_neg <= 1'b0;
            r2_err <= 1'b0;
        end else if (ld[1]) begin
            r2_y   <= w_y;
            r2_neg <= r1_neg;
            r2_err <= r1_err;
        end
    end

    // Stage 3: mirror for negative inputs, then tanh = 2*s - 1.
    always_comb begin
        w_ys   = r2_neg ? (c_one - r2_y) : r2_y;
        w_tanh = {w_ys[DW-2:0], 1'b0} - c_one;
        if (!en) begin
            w_res = c_zero;
        end else if (r2_err) begin
            w_res = (op_e'(op_s3) == OP_TANH) ? (c_zero - c_one) : c_zero;
        end else begin
            w_res = (op_e'(op_s3) == OP_TANH) ? w_tanh : w_ys;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            y   <= '0;
            err <= 1'b0;
        end else if (flush) begin
            y   <= '0;
            err <= 1'b0;
        end else if (ld[2]) begin
            y   <= w_res;
            err <= en & r2_err;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sigmoid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sigmoid_pipe
// Description : Multi-lane elastic 3-stage sigmoid/tanh pipe with tag passthrough.
// Revision    : 1.0 - initial release
// ============================================================================
module sigmoid_pipe
    import sigmoid_pkg::*;
#(
    parameter int LANES = c_tag_lanes,
    parameter int DW    = 32,
    parameter int FRAC  = 16,
    parameter int IDXW  = c_tag_idxw
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                op,
    input  logic                flush,
    input  logic                reg_wen,
    input  logic [LANES-1:0]    word_sel,
    input  logic [IDXW-1:0]     index,
    input  logic [LANES*DW-1:0] data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] result,
    output logic [LANES-1:0]    error,
    output logic                reg_wen_o,
    output logic [LANES-1:0]    word_sel_o,
    output logic [IDXW-1:0]     index_o,
    output logic                empty
);

    logic       r_v1;
    logic       r_v2;
    logic       r_v3;
    logic       w_ld1;
    logic       w_ld2;
    logic       w_ld3;
    logic       w_dld1;
    logic       w_dld2;
    logic       w_dld3;
    stage_tag_t w_tag_in;
    stage_tag_t r_tag1;
    stage_tag_t r_tag2;

    // A stage may take new content when it is empty or its content moves on.
    assign w_ld3     = ~r_v3 | out_ready;
    assign w_ld2     = ~r_v2 | w_ld3;
    assign w_ld1     = ~r_v1 | w_ld2;
    assign in_ready  = ~flush & w_ld1;
    assign out_valid = r_v3;
    assign empty     = ~(r_v1 | r_v2 | r_v3);

    assign w_dld1 = in_valid & in_ready;
    assign w_dld2 = ~flush & w_ld2 & r_v1;
    assign w_dld3 = ~flush & w_ld3 & r_v2;

    always_comb begin
        w_tag_in          = '0;
        w_tag_in.reg_wen  = reg_wen;
        w_tag_in.word_sel = word_sel;
        w_tag_in.index    = index;
        w_tag_in.op       = op_e'(op);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_ld3) r_v3 <= r_v2;
            if (w_ld2) r_v2 <= r_v1;
            if (w_ld1) r_v1 <= in_valid;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_tag1 <= '0;
            r_tag2 <= '0;
        end else begin
            if (w_dld1) r_tag1 <= w_tag_in;
            if (w_dld2) r_tag2 <= r_tag1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            reg_wen_o  <= 1'b0;
            word_sel_o <= '0;
            index_o    <= '0;
        end else if (flush) begin
            reg_wen_o  <= 1'b0;
            word_sel_o <= '0;
            index_o    <= '0;
        end else if (w_dld3) begin
            reg_wen_o  <= r_tag2.reg_wen;
            word_sel_o <= r_tag2.word_sel;
            index_o    <= r_tag2.index;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sigmoid_lane #(
            .DW   (DW),
            .FRAC (FRAC)
        ) u_lane (
            .CLK   (CLK),
            .nRST  (nRST),
            .ld    ({w_dld3, w_dld2, w_dld1}),
            .flush (flush),
            .op_s1 (op),
            .op_s3 (r_tag2.op),
            .en    (r_tag2.word_sel[k]),
            .x     (data[k*DW +: DW]),
            .y     (result[k*DW +: DW]),
            .err   (error[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sigmoid_pipe
// Description : Self-checking bench for sigmoid_pipe against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sigmoid_pipe;

    logic         CLK;
    logic         nRST;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic         flush;
    logic         reg_wen;
    logic [3:0]   word_sel;
    logic [4:0]   index;
    logic [127:0] data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;
    logic [3:0]   error;
    logic         reg_wen_o;
    logic [3:0]   word_sel_o;
    logic [4:0]   index_o;
    logic         empty;

    sigmoid_pipe #(.LANES(4), .DW(32), .FRAC(16), .IDXW(5)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .flush      (flush),
        .reg_wen    (reg_wen),
        .word_sel   (word_sel),
        .index      (index),
        .data       (data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .error      (error),
        .reg_wen_o  (reg_wen_o),
        .word_sel_o (word_sel_o),
        .index_o    (index_o),
        .empty      (empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [127:0] res;
        logic [3:0]   err;
        logic         rw;
        logic [3:0]   ws;
        logic [4:0]   idx;
        int           acc;
    } exp_t;

    exp_t         q[$];
    int           n_assert = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           n_acc    = 0;
    int           n_drained = 0;
    bit           stalled_prev = 0;
    bit           saw_block = 0;
    logic [127:0] prev_res;
    logic [9:0]   prev_tag;
    logic [127:0] last_res;
    logic [3:0]   last_err;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: sigmoid by the segment table on |x|, mirrored for x<0; tanh = 2*sig(2x)-1.
    function automatic logic [32:0] ref_lane(input logic t, input logic [31:0] x);
        longint one, lmin, lmax, v, a, y;
        one  = 65536;
        lmin = -(longint'(1) <<< 31);
        lmax = (longint'(1) <<< 31) - 1;
        v    = longint'($signed(x));
        if (v == lmin) return {1'b1, (t ? 32'hFFFF_0000 : 32'h0000_0000)};
        if (t) begin
            v = 2 * v;
            if (v > lmax) v = lmax;
            if (v < lmin) v = lmin;
        end
        a = (v < 0) ? -v : v;
        if (a >= 5 * one)            y = one;
        else if (8 * a >= 19 * one)  y = a / 32 + (27 * one) / 32;
        else if (a >= one)           y = a / 8 + (5 * one) / 8;
        else                         y = a / 4 + one / 2;
        if (v < 0) y = one - y;
        if (t) y = 2 * y - one;
        return {1'b0, y[31:0]};
    endfunction

    function automatic exp_t model(input logic t, input logic [3:0] ws, input logic [127:0] d,
                                   input logic rw, input logic [4:0] idx, input int c);
        exp_t        e;
        logic [32:0] r;
        e.res = '0;
        e.err = '0;
        for (int k = 0; k < 4; k++) begin
            if (ws[k]) begin
                r = ref_lane(t, d[k*32 +: 32]);
                e.res[k*32 +: 32] = r[31:0];
                e.err[k] = r[32];
            end
        end
        e.rw  = rw;
        e.ws  = ws;
        e.idx = idx;
        e.acc = c;
        return e;
    endfunction

    function automatic logic [31:0] rnd_lane();
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return 32'($urandom_range(0, 32'h000C_0000)) - 32'h0006_0000;
            2: begin
                case ($urandom_range(0, 5))
                    0: return 32'h0001_0000;
                    1: return 32'h0002_6000;
                    2: return 32'h0005_0000;
                    3: return 32'hFFFB_0000;
                    4: return 32'h0001_3000;
                    default: return 32'h0002_5FFF;
                endcase
            end
            3: return 32'h8000_0000;
            4: return 32'h4000_0000 + 32'($urandom_range(0, 255));
            default: return 32'($urandom_range(0, 32'h0001_FFFF));
        endcase
    endfunction

    task automatic rand_bundle();
        op       = 1'($urandom_range(0, 1));
        reg_wen  = 1'($urandom_range(0, 1));
        word_sel = 4'($urandom_range(0, 15));
        index    = 5'($urandom_range(0, 31));
        data     = {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
    endtask

    // One clock: check the handshake state at the falling edge, then advance.
    task automatic tick();
        exp_t e;
        bit   drn;
        bit   acc;
        bit   exp_ov;
        @(negedge CLK);
        exp_ov = 1'b0;
        if (q.size() > 0) exp_ov = (cyc - q[0].acc >= 3);
        check("in_ready", 128'(in_ready), 128'(!flush && (q.size() < 3 || out_ready)));
        check("empty", 128'(empty), 128'(q.size() == 0));
        check("out_valid", 128'(out_valid), 128'(exp_ov));
        if (stalled_prev) begin
            check("stall_result", result, prev_res);
            check("stall_tag", 128'({reg_wen_o, word_sel_o, index_o}), 128'(prev_tag));
        end
        acc = in_valid && in_ready;
        drn = out_valid && out_ready && !flush;
        if (drn && q.size() > 0) begin
            e = q.pop_front();
            check("result", result, e.res);
            check("error", 128'(error), 128'(e.err));
            check("tags", 128'({reg_wen_o, word_sel_o, index_o}), 128'({e.rw, e.ws, e.idx}));
            last_res = result;
            last_err = error;
            n_drained++;
        end
        if (acc) begin
            q.push_back(model(op, word_sel, data, reg_wen, index, cyc));
            n_acc++;
        end
        if (in_valid && !in_ready) saw_block = 1'b1;
        stalled_prev = out_valid && !out_ready && !flush;
        prev_res     = result;
        prev_tag     = {reg_wen_o, word_sel_o, index_o};
        @(posedge CLK);
        cyc++;
        if (flush) q.delete();
        #1;
    endtask

    task automatic send(input logic t, input logic [3:0] ws, input logic [127:0] d);
        int a0;
        op       = t;
        word_sel = ws;
        data     = d;
        reg_wen  = 1'b1;
        index    = 5'($urandom_range(0, 31));
        in_valid = 1'b1;
        a0 = n_acc;
        for (int i = 0; i < 10 && n_acc == a0; i++) tick();
        check("send_accept", 128'(in_ready), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && q.size() > 0; i++) tick();
        check("drain_empty", 128'(empty), 128'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        int d0;
        int a0;
        nRST = 1'b0; in_valid = 1'b0; op = 1'b0; flush = 1'b0; reg_wen = 1'b0;
        word_sel = '0; index = '0; data = '0; out_ready = 1'b1;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_result", result, 128'(0));
        check("rst_error", 128'(error), 128'(0));
        check("rst_tags", 128'({reg_wen_o, word_sel_o, index_o}), 128'(0));
        check("rst_empty", 128'(empty), 128'(1));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        tick();
        tick();

        // Directed values.
        send(1'b0, 4'hF, {32'h0006_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0000_0000});
        wait_drain(10);
        check("sig_vec_res", last_res, 128'h00010000_00004000_0000C000_00008000);
        check("sig_vec_err", 128'(last_err), 128'(0));

        send(1'b1, 4'h3, {32'h1234_5678, 32'h8000_0000, 32'h0000_4000, 32'h0000_0000});
        wait_drain(10);
        check("tanh_vec_res", last_res, 128'h00000000_00000000_00004000_00000000);
        check("tanh_vec_err", 128'(last_err), 128'(0));

        send(1'b0, 4'h1, {32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h8000_0000});
        wait_drain(10);
        check("sig_ovf_res", last_res, 128'(0));
        check("sig_ovf_err", 128'(last_err), 128'(1));

        send(1'b1, 4'hF, {4{32'h8000_0000}});
        wait_drain(10);
        check("tanh_ovf_res", last_res, 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000);
        check("tanh_ovf_err", 128'(last_err), 128'(4'hF));

        // Six bundles with the consumer stalled for a few cycles.
        n0 = n_acc; d0 = n_drained; saw_block = 1'b0;
        rand_bundle();
        in_valid = 1'b1;
        for (int i = 0; i < 40 && n_acc - n0 < 6; i++) begin
            out_ready = !(i >= 2 && i <= 5);
            a0 = n_acc;
            tick();
            if (n_acc != a0) rand_bundle();
        end
        in_valid = 1'b0;
        wait_drain(20);
        check("stream_drained", 128'(n_drained - d0), 128'(6));
        check("stream_blocked", 128'(saw_block), 128'(1));

        // Flush with three bundles in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_bundle();
            in_valid = 1'b1;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("flush_empty", 128'(empty), 128'(1));

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            rand_bundle();
            in_valid = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
            tick();
        end
        flush = 1'b0;
        wait_drain(20);

        // Asynchronous reset in the middle of a stream.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_bundle();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_result", result, 128'(0));
        check("mid_rst_error", 128'(error), 128'(0));
        check("mid_rst_tags", 128'({reg_wen_o, word_sel_o, index_o}), 128'(0));
        check("mid_rst_empty", 128'(empty), 128'(1));
        nRST = 1'b1;
        q.delete();
        stalled_prev = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sigmoid_pipe.md
SIGMOID_PIPE -- requirements
Module: sigmoid_pipe

Interface
REQ-001 Parameters SHALL be: LANES, 4, number of parallel lanes; DW, 32, lane data width; FRAC, 16, fractional bits (two's-complement Q(DW-FRAC).FRAC); IDXW, 5, writeback index width.
REQ-002 Ports SHALL be: CLK  in  1  clock; nRST  in  1  reset, asynchronous, active-low; both fixed decisions.
REQ-003 in_valid  in  1  input bundle valid; in_ready  out  1  pipe accepts this cycle.
REQ-004 op  in  1  0 = sigmoid, 1 = tanh; flush  in  1  discard all in-flight bundles.
REQ-005 reg_wen  in  1; word_sel  in  LANES  one-hot-per-lane write enable; index  in  IDXW  base register; all carried as tag.
REQ-006 data  in  LANES*DW  lane k at bits [k*DW +: DW].
REQ-007 out_valid  out  1; out_ready  in  1  consumer accepts.
REQ-008 result  out  LANES*DW; error  out  LANES  per-lane error; reg_wen_o  out  1; word_sel_o  out  LANES; index_o  out  IDXW.
REQ-009 empty  out  1  high when no pipe stage holds a valid bundle.

Function
REQ-010 Pipe SHALL have 3 registered stages: S1 abs value + segment select, S2 shift-add evaluation, S3 sign correction + tanh post-scale; outputs driven from S3 registers.
REQ-011 Latency SHALL be 3 cycles from accept (in_valid & in_ready) to out_valid with out_ready held high; throughput 1 bundle/cycle.
REQ-012 Handshake: elastic per stage; stage advances when empty or downstream advances; in_ready = !flush & (S1 empty | S1 advancing); out_valid/result SHALL hold stable while out_valid & !out_ready.
REQ-013 Sigmoid (PLAN) on a = |x|: a>=5.0 -> 1.0; 2.375<=a<5.0 -> a/32+0.84375; 1.0<=a<2.375 -> a/8+0.625; a<1.0 -> a/4+0.5; breakpoints belong to upper segment.
REQ-014 x<0 SHALL return 1.0 - y; shifts truncate toward zero on a; result range [0, 1.0].
REQ-015 Tanh SHALL compute 2*sigmoid(2x) - 1; 2x overflow saturates to max/min representable before evaluation.
REQ-016 error[k] SHALL be high when lane input equals -2^(DW-1) (abs overflow); result then forced to 0 (sigmoid) or -1.0 (tanh).
REQ-017 Lanes with word_sel bit 0 SHALL output result 0 and error 0; tag fields pass unchanged with their bundle.
REQ-018 flush SHALL clear all stage valid bits at the next edge, including S3 held under backpressure; in_valid ignored that cycle.
REQ-019 Simultaneous accept and output drain in one cycle SHALL both occur with no bubble.
REQ-020 empty SHALL be combinational NOR of the three stage valid bits.

Reset
REQ-021 nRST low SHALL asynchronously clear all valid bits, result, error, reg_wen_o, word_sel_o, index_o to 0; empty = 1, in_ready = 1 after reset deassertion.
REQ-022 Reset mid-operation SHALL drop all in-flight bundles; no out_valid for them.

Structure
REQ-023 Package sigmoid_pkg SHALL hold op enum (OP_SIG, OP_TANH), breakpoint constants (1.0, 2.375, 5.0), segment offsets and a stage-tag struct {reg_wen, word_sel, index, op}.
REQ-024 Per-lane datapath SHALL be sub-module sigmoid_lane (3 registered stages, stall/flush inputs), instantiated LANES times by generate; control/valid chain lives in sigmoid_pipe.

Verification (LANES=4, DW=32, FRAC=16)
REQ-025 op=0, data lanes {0x00000000, 0x00010000, 0xFFFF0000, 0x00060000}, word_sel=4'hF -> 3 cycles later result {0x00008000, 0x0000C000, 0x00004000, 0x00010000}, error 0.
REQ-026 op=1, lanes {0x00000000, 0x00004000, x, x}, word_sel=4'h3 -> result {0x00000000, 0x00004000, 0, 0}.
REQ-027 Lane input 0x80000000, op=0 -> error bit 1, result lane 0.
REQ-028 Stream 6 bundles, out_ready low cycles 2-5 -> in_ready low once full, no bundle lost or duplicated, order preserved, result stable while stalled.
REQ-029 Flush with 3 bundles in flight -> no out_valid next 3 cycles, empty=1 one cycle after flush.
REQ-030 nRST asserted mid-stream -> outputs 0 immediately, empty=1, tag outputs 0.
